// File: rtl/llc_mem_bridge_pkg.sv
// Shared constants and payload types for the llc_core memory-side bridge.
// LINE_W / BEAT_W / BEATS / OFF_W describe the line-to-beat geometry; the
// mem_* structs describe the payloads of the beat-serial memory port.
package llc_mem_bridge_pkg;

    localparam int LINE_ADDR_W = 28;
    localparam int LINE_W      = 128;
    localparam int BEAT_W      = 32;
    localparam int HPROT_W     = 4;
    localparam int BEATS       = LINE_W / BEAT_W;
    localparam int OFF_W       = $clog2(LINE_W / 8);
    localparam int CNT_W       = $clog2(BEATS);
    localparam int MEM_ADDR_W  = LINE_ADDR_W + OFF_W;
    localparam int LEN_W       = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_WDATA,
        S_WACK,
        S_RDATA,
        S_RSP
    } state_t;

    typedef struct packed {
        logic                  write;
        logic [MEM_ADDR_W-1:0] addr;
        logic [HPROT_W-1:0]    hprot;
        logic [LEN_W-1:0]      len;
    } mem_cmd_t;

    typedef struct packed {
        logic [BEAT_W-1:0] data;
        logic              last;
    } mem_wdata_t;

    typedef struct packed {
        logic [BEAT_W-1:0] data;
        logic              last;
    } mem_rdata_t;

endpackage

// File: rtl/llc_mem_bridge_if.sv
// Bundle of every handshake channel around the bridge: the core's line
// request/response channels plus the memory cmd/wdata/rdata/wack channels.
//   slave  : view used by the bridge (serves core requests, drives memory)
//   master : view used by the environment (core + memory)
interface llc_mem_bridge_if;
    import llc_mem_bridge_pkg::*;

    logic                   llc_mem_req_valid;
    logic                   llc_mem_req_ready;
    logic                   llc_mem_req_hwrite;
    logic [LINE_ADDR_W-1:0] llc_mem_req_addr;
    logic [HPROT_W-1:0]     llc_mem_req_hprot;
    logic [LINE_W-1:0]      llc_mem_req_line;

    logic                   llc_mem_rsp_valid;
    logic                   llc_mem_rsp_ready;
    logic [LINE_W-1:0]      llc_mem_rsp_line;

    logic                   mem_cmd_valid;
    logic                   mem_cmd_ready;
    logic                   mem_cmd_write;
    logic [MEM_ADDR_W-1:0]  mem_cmd_addr;
    logic [HPROT_W-1:0]     mem_cmd_hprot;
    logic [LEN_W-1:0]       mem_cmd_len;

    logic                   mem_wdata_valid;
    logic                   mem_wdata_ready;
    logic [BEAT_W-1:0]      mem_wdata;
    logic                   mem_wdata_last;

    logic                   mem_rdata_valid;
    logic                   mem_rdata_ready;
    logic [BEAT_W-1:0]      mem_rdata;
    logic                   mem_rdata_last;

    logic                   mem_wack_valid;
    logic                   mem_wack_ready;

    modport slave (
        input  llc_mem_req_valid, llc_mem_req_hwrite, llc_mem_req_addr,
               llc_mem_req_hprot, llc_mem_req_line, llc_mem_rsp_ready,
               mem_cmd_ready, mem_wdata_ready, mem_rdata_valid, mem_rdata,
               mem_rdata_last, mem_wack_valid,
        output llc_mem_req_ready, llc_mem_rsp_valid, llc_mem_rsp_line,
               mem_cmd_valid, mem_cmd_write, mem_cmd_addr, mem_cmd_hprot,
               mem_cmd_len, mem_wdata_valid, mem_wdata, mem_wdata_last,
               mem_rdata_ready, mem_wack_ready
    );

    modport master (
        output llc_mem_req_valid, llc_mem_req_hwrite, llc_mem_req_addr,
               llc_mem_req_hprot, llc_mem_req_line, llc_mem_rsp_ready,
               mem_cmd_ready, mem_wdata_ready, mem_rdata_valid, mem_rdata,
               mem_rdata_last, mem_wack_valid,
        input  llc_mem_req_ready, llc_mem_rsp_valid, llc_mem_rsp_line,
               mem_cmd_valid, mem_cmd_write, mem_cmd_addr, mem_cmd_hprot,
               mem_cmd_len, mem_wdata_valid, mem_wdata, mem_wdata_last,
               mem_rdata_ready, mem_wack_ready
    );

endinterface

// File: rtl/llc_line_serdes.sv
// Line buffer plus beat counter. Serialises a latched writeback line into
// beats (beat 0 = LSBs) and assembles returned read beats into a line.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   load_i       latch line_i into the buffer (request accept)
//   line_i       writeback line from the core
//   clr_i        clear the beat counter (command accept)
//   wr_adv_i     a write beat was accepted, advance the counter
//   rd_push_i    a read beat was accepted, store it and advance the counter
//   rd_beat_i    read beat data
//   wbeat_o      current write beat slice and "counter at last beat" flag
//   line_o       buffer contents (assembled fill line)
module llc_line_serdes
    import llc_mem_bridge_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [LINE_W-1:0] line_i,
    input  logic              clr_i,
    input  logic              wr_adv_i,
    input  logic              rd_push_i,
    input  logic [BEAT_W-1:0] rd_beat_i,
    output mem_wdata_t        wbeat_o,
    output logic [LINE_W-1:0] line_o
);

    logic [BEATS-1:0][BEAT_W-1:0] line_q, line_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic                         at_last;

    assign at_last = (cnt_q == CNT_W'(BEATS - 1));

    always_comb begin
        line_d = line_q;
        cnt_d  = cnt_q;
        if (load_i)
            line_d = line_i;
        if (rd_push_i)
            line_d[cnt_q] = rd_beat_i;
        // Wrap to 0 only after the final beat so the counter is clean for
        // the next transaction even if BEATS is not a power of two.
        if (clr_i)
            cnt_d = '0;
        else if (wr_adv_i || rd_push_i)
            cnt_d = at_last ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            line_q <= '0;
            cnt_q  <= '0;
        end else begin
            line_q <= line_d;
            cnt_q  <= cnt_d;
        end
    end

    assign wbeat_o.data = line_q[cnt_q];
    assign wbeat_o.last = at_last;
    assign line_o       = line_q;

endmodule

// File: rtl/llc_mem_bridge.sv
// Bridge between llc_core's line-granular memory channel and a beat-serial
// ready/valid memory port. One transaction in flight: writebacks are sent
// as cmd + BEATS write beats and retire silently on the write ack; fills are
// sent as cmd, BEATS read beats are gathered, and the line is returned.
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   bus       all core/memory channels (llc_mem_bridge_if.slave)
//   err       sticky flag: mem_rdata_last disagreed with the beat count
module llc_mem_bridge
    import llc_mem_bridge_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    llc_mem_bridge_if.slave  bus,
    output logic             err
);

    state_t                 state_q;
    logic                   req_ready_q;
    logic                   cmd_valid_q;
    logic                   wdata_valid_q;
    logic                   wack_ready_q;
    logic                   rdata_ready_q;
    logic                   rsp_valid_q;
    logic                   err_q;
    logic                   hwrite_q;
    logic [LINE_ADDR_W-1:0] addr_q;
    logic [HPROT_W-1:0]     hprot_q;

    logic req_fire, cmd_fire, wdata_fire, wack_fire, rdata_fire, rsp_fire;

    mem_wdata_t        wbeat;
    mem_rdata_t        rbeat;
    mem_cmd_t          cmd;
    logic [LINE_W-1:0] line;

    // All valid/ready outputs are registered, so fires never loop back
    // combinationally into the far side.
    assign req_fire   = bus.llc_mem_req_valid & req_ready_q;
    assign cmd_fire   = cmd_valid_q & bus.mem_cmd_ready;
    assign wdata_fire = wdata_valid_q & bus.mem_wdata_ready;
    assign wack_fire  = bus.mem_wack_valid & wack_ready_q;
    assign rdata_fire = bus.mem_rdata_valid & rdata_ready_q;
    assign rsp_fire   = rsp_valid_q & bus.llc_mem_rsp_ready;

    assign rbeat = '{data: bus.mem_rdata, last: bus.mem_rdata_last};

    llc_line_serdes u_serdes (
        .clk       (clk),
        .rst       (rst),
        .load_i    (req_fire),
        .line_i    (bus.llc_mem_req_line),
        .clr_i     (cmd_fire),
        .wr_adv_i  (wdata_fire),
        .rd_push_i (rdata_fire),
        .rd_beat_i (rbeat.data),
        .wbeat_o   (wbeat),
        .line_o    (line)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            req_ready_q   <= 1'b1;
            cmd_valid_q   <= 1'b0;
            wdata_valid_q <= 1'b0;
            wack_ready_q  <= 1'b0;
            rdata_ready_q <= 1'b0;
            rsp_valid_q   <= 1'b0;
            err_q         <= 1'b0;
            hwrite_q      <= 1'b0;
            addr_q        <= '0;
            hprot_q       <= '0;
        end else begin
            // The beat count ends a read; a last flag that disagrees with
            // it is only flagged, the transfer carries on regardless.
            if (rdata_fire && (rbeat.last != wbeat.last))
                err_q <= 1'b1;

            case (state_q)
                S_IDLE: if (req_fire) begin
                    hwrite_q    <= bus.llc_mem_req_hwrite;
                    addr_q      <= bus.llc_mem_req_addr;
                    hprot_q     <= bus.llc_mem_req_hprot;
                    req_ready_q <= 1'b0;
                    cmd_valid_q <= 1'b1;
                    state_q     <= S_CMD;
                end
                S_CMD: if (cmd_fire) begin
                    cmd_valid_q <= 1'b0;
                    if (hwrite_q) begin
                        wdata_valid_q <= 1'b1;
                        state_q       <= S_WDATA;
                    end else begin
                        rdata_ready_q <= 1'b1;
                        state_q       <= S_RDATA;
                    end
                end
                S_WDATA: if (wdata_fire && wbeat.last) begin
                    wdata_valid_q <= 1'b0;
                    wack_ready_q  <= 1'b1;
                    state_q       <= S_WACK;
                end
                S_WACK: if (wack_fire) begin
                    wack_ready_q <= 1'b0;
                    req_ready_q  <= 1'b1;
                    state_q      <= S_IDLE;
                end
                S_RDATA: if (rdata_fire && wbeat.last) begin
                    rdata_ready_q <= 1'b0;
                    rsp_valid_q   <= 1'b1;
                    state_q       <= S_RSP;
                end
                S_RSP: if (rsp_fire) begin
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: begin
                    req_ready_q   <= 1'b1;
                    cmd_valid_q   <= 1'b0;
                    wdata_valid_q <= 1'b0;
                    wack_ready_q  <= 1'b0;
                    rdata_ready_q <= 1'b0;
                    rsp_valid_q   <= 1'b0;
                    state_q       <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd = '{write: hwrite_q,
                   addr:  {addr_q, {OFF_W{1'b0}}},
                   hprot: hprot_q,
                   len:   LEN_W'(BEATS - 1)};

    assign bus.llc_mem_req_ready = req_ready_q;
    assign bus.llc_mem_rsp_valid = rsp_valid_q;
    assign bus.llc_mem_rsp_line  = line;

    assign bus.mem_cmd_valid   = cmd_valid_q;
    assign bus.mem_cmd_write   = cmd.write;
    assign bus.mem_cmd_addr    = cmd.addr;
    assign bus.mem_cmd_hprot   = cmd.hprot;
    assign bus.mem_cmd_len     = cmd.len;

    assign bus.mem_wdata_valid = wdata_valid_q;
    assign bus.mem_wdata       = wbeat.data;
    assign bus.mem_wdata_last  = wbeat.last;

    assign bus.mem_rdata_ready = rdata_ready_q;
    assign bus.mem_wack_ready  = wack_ready_q;

    assign err = err_q;

endmodule
